// File: rtl/spm_pkg.sv
// spm_pkg: shared state encoding and constants for the stored-program machine loader
package spm_pkg;
    localparam int ADDR_W = 8;
    localparam logic [7:0] SYNC_DEF = 8'hA5;
    localparam logic CPU_RST_ACT = 1'b0;
    typedef enum logic [3:0] {
        S_HDR, S_LEN, S_DATA, S_CHK, S_WAIT, S_START, S_RUN, S_HALT, S_ERR
    } state_t;
endpackage

// File: rtl/spm_prog_loader_if.sv
// spm_prog_loader_if: byte-stream handshake plus program-memory write port
interface spm_prog_loader_if;
    import spm_pkg::*;
    logic in_valid;
    logic [7:0] in_data;
    logic in_ready;
    logic mem_sel;
    logic mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0] mem_wdata;
    modport slave(input in_valid, in_data, output in_ready, mem_sel, mem_we, mem_addr, mem_wdata);
    modport master(output in_valid, in_data, input in_ready, mem_sel, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/spm_loader_timeout.sv
// spm_loader_timeout: idle counter that expires after CYC consecutive enabled cycles
module spm_loader_timeout #(
    parameter int CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(CYC);
    localparam logic [W-1:0] LAST = W'(CYC - 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && cnt != LAST) cnt <= cnt + W'(1);
    assign expire = en && cnt == LAST;
endmodule

// File: rtl/spm_prog_loader.sv
// spm_prog_loader: framed program loader and CPU run control.
// Define SPM_LOADER_CHKSUM_EN to require a trailing checksum byte per frame.
module spm_prog_loader
    import spm_pkg::*;
#(
    parameter logic [ADDR_W-1:0] LOAD_BASE = 8'h00,
    parameter logic [7:0] SYNC_BYTE = SYNC_DEF,
    parameter int TIMEOUT_CYC = 1024,
    parameter bit AUTO_RUN = 1'b1
) (
    input  logic clk,
    input  logic rst,
    spm_prog_loader_if.slave bus,
    input  logic run_i,
    input  logic halt_i,
    output logic cpu_rst_n,
    output logic busy,
    output logic running,
    output logic done,
    output logic err
);
    state_t state, nxt, load_nxt;
    logic [ADDR_W-1:0] addr;
    logic [8:0] cnt;
    logic live, xfer, sync, expire;
`ifdef SPM_LOADER_CHKSUM_EN
    logic [7:0] sum;
`endif
    // in_ready is held low until the first edge after reset release
    assign bus.in_ready = live && !(state inside {S_WAIT, S_START});
    assign bus.mem_sel = !(state inside {S_START, S_RUN, S_HALT});
    assign xfer = bus.in_valid && bus.in_ready;
    assign sync = xfer && bus.in_data == SYNC_BYTE;
    assign bus.mem_we = state == S_DATA && xfer;
    assign bus.mem_addr = addr;
    assign bus.mem_wdata = bus.in_data;
    assign busy = state inside {S_LEN, S_DATA, S_CHK};
    assign running = state == S_RUN;
    assign done = state == S_HALT;
    assign err = state == S_ERR;
    assign load_nxt = AUTO_RUN ? S_START : S_WAIT;
    spm_loader_timeout #(.CYC(TIMEOUT_CYC)) u_timeout (
        .clk, .rst, .clr(xfer || nxt != state), .en(busy), .expire
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= S_HDR;
        else state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            S_HDR, S_ERR: nxt = sync ? S_LEN : state;
            S_LEN: nxt = xfer ? S_DATA : expire ? S_ERR : state;
`ifdef SPM_LOADER_CHKSUM_EN
            S_DATA: nxt = xfer && cnt == 9'd1 ? S_CHK : expire ? S_ERR : state;
            S_CHK: nxt = xfer ? (8'(sum + bus.in_data) == 8'h00 ? load_nxt : S_ERR) : expire ? S_ERR : state;
`else
            S_DATA: nxt = xfer && cnt == 9'd1 ? load_nxt : expire ? S_ERR : state;
`endif
            S_WAIT: nxt = run_i ? S_START : state;
            S_START: nxt = S_RUN;
            S_RUN: nxt = sync ? S_LEN : halt_i ? S_HALT : state;
            S_HALT: nxt = sync ? S_LEN : state;
            default: nxt = S_HDR;
        endcase
    end
    // a LEN byte of zero encodes a 256-byte frame
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            addr <= LOAD_BASE;
            cnt <= '0;
            live <= 1'b0;
            cpu_rst_n <= CPU_RST_ACT;
        end else begin
            live <= 1'b1;
            cpu_rst_n <= nxt inside {S_RUN, S_HALT} ? !CPU_RST_ACT : CPU_RST_ACT;
            if (state == S_LEN && xfer) begin
                addr <= LOAD_BASE;
                cnt <= {bus.in_data == 8'h00, bus.in_data};
            end else if (bus.mem_we) begin
                addr <= addr + ADDR_W'(1);
                cnt <= cnt - 9'd1;
            end
        end
`ifdef SPM_LOADER_CHKSUM_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) sum <= '0;
        else if (state == S_LEN) sum <= '0;
        else if (bus.mem_we) sum <= sum + bus.in_data;
`endif
endmodule

// File: tb/tb_spm_prog_loader.sv
// tb_spm_prog_loader: frame table plus run-control sequences, memory writes checked via scoreboard
module tb_spm_prog_loader;
    localparam logic [7:0] LB = 8'hFE;
    localparam int TO = 16;
    localparam logic [7:0] V_RST  = 8'b0100_0000;
    localparam logic [7:0] V_HDR  = 8'b0101_0000;
    localparam logic [7:0] V_BUSY = 8'b0101_1000;
    localparam logic [7:0] V_RUN  = 8'b1001_0100;
    localparam logic [7:0] V_HALT = 8'b1001_0010;
    localparam logic [7:0] V_ERR  = 8'b0101_0001;
    typedef struct {
        logic [7:0] len;
        logic [7:0] d0;
        logic [7:0] step;
        int nw;
    } frame_t;
    logic clk = 1'b0, rst = 1'b0, run_i = 1'b0, halt_i = 1'b0;
    logic cpu_rst_n, busy, running, done, err;
    int checks = 0, errors = 0, nwr = 0;
    logic [31:0] q[$];
    frame_t tbl[5];
    spm_prog_loader_if bus();
    spm_prog_loader #(
        .LOAD_BASE(LB), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TO), .AUTO_RUN(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .run_i(run_i), .halt_i(halt_i),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .running(running), .done(done), .err(err)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // {cpu_rst_n, mem_sel, mem_we, in_ready, busy, running, done, err}
    function automatic logic [31:0] st();
        return 32'({cpu_rst_n, bus.mem_sel, bus.mem_we, bus.in_ready, busy, running, done, err});
    endfunction
    task automatic send(input logic [7:0] b);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data = b;
        while (!bus.in_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("in_ready", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask
    task automatic send_data(input logic [7:0] a, input logic [7:0] d);
        q.push_back(32'({1'b1, a, d}));
        send(d);
    endtask
    task automatic send_body(input logic [7:0] len, input logic [7:0] d0, input logic [7:0] step, input int nw);
        logic [7:0] d, a, s;
        d = d0;
        a = LB;
        s = 8'h00;
        send(len);
        for (int i = 0; i < nw; i++) begin
            send_data(a, d);
            s = s + d;
            a = a + 8'd1;
            d = d + step;
        end
`ifdef SPM_LOADER_CHKSUM_EN
        send(8'(8'h00 - s));
`endif
    endtask
    task automatic start_check();
        chk("start_state", st(), 32'h0);
        @(posedge clk);
        #1;
        chk("run_state", st(), V_RUN);
    endtask
    always @(negedge clk)
        if (rst && bus.mem_we) begin
            nwr++;
            chk("mem_write", 32'({bus.mem_sel, bus.mem_addr, bus.mem_wdata}),
                q.size() != 0 ? q.pop_front() : 32'hDEADBEEF);
        end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        tbl[0] = '{8'h03, 8'h11, 8'h11, 3};
        tbl[1] = '{8'h04, 8'h01, 8'h01, 4};
        tbl[2] = '{8'h01, 8'hA5, 8'h00, 1};
        tbl[3] = '{8'h02, 8'h7E, 8'h03, 2};
        tbl[4] = '{8'h00, 8'h00, 8'h01, 256};
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        #12 chk("reset_values", st(), V_RST);
        #9 rst = 1'b1;
        @(posedge clk);
        #1 chk("hdr_idle", st(), V_HDR);
        send(8'h7E);
        chk("hdr_discard", st(), V_HDR);
        foreach (tbl[k]) begin
            nwr = 0;
            send(8'hA5);
            chk("sync_to_len", st(), V_BUSY);
            send_body(tbl[k].len, tbl[k].d0, tbl[k].step, tbl[k].nw);
            chk("write_count", 32'(nwr), 32'(tbl[k].nw));
            start_check();
        end
        send(8'h7E);
        chk("run_discard", st(), V_RUN);
        halt_i = 1'b1;
        @(posedge clk);
        #1 chk("halt", st(), V_HALT);
        halt_i = 1'b0;
        send(8'hA5);
        chk("halt_sync", st(), V_BUSY);
        send(8'h02);
        send_data(LB, 8'h11);
        repeat (TO - 1) @(posedge clk);
        #1 chk("pre_timeout", st(), V_BUSY);
        @(posedge clk);
        #1 chk("timeout_err", st(), V_ERR);
        send(8'h7E);
        chk("err_discard", st(), V_ERR);
        send(8'hA5);
        chk("err_sync", st(), V_BUSY);
        send_body(8'h03, 8'h40, 8'h01, 3);
        start_check();
        halt_i = 1'b1;
        send(8'hA5);
        halt_i = 1'b0;
        chk("abort_beats_halt", st(), V_BUSY);
        send_body(8'h01, 8'h5A, 8'h00, 1);
        start_check();
        #2 rst = 1'b0;
        #1 chk("async_reset", st(), V_RST);
        #4 rst = 1'b1;
        @(posedge clk);
        #1 chk("hdr_after_reset", st(), V_HDR);
`ifdef SPM_LOADER_CHKSUM_EN
        send(8'hA5);
        send(8'h03);
        send_data(LB, 8'h11);
        send_data(8'(LB + 8'd1), 8'h22);
        send_data(8'(LB + 8'd2), 8'h33);
        send(8'h9B);
        chk("bad_checksum", st(), V_ERR);
`endif
        chk("scoreboard_empty", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spm_prog_loader.md
Name: spm_prog_loader

Overview:
Run-control and program-load sequencer for the stored-program machine. It owns the CPU's active-low run reset and the memory write-port mux. It accepts a framed byte stream (SYNC, LEN, data[, CHK]) on a valid/ready interface and writes the data into program memory starting at LOAD_BASE. It then releases the CPU, monitors the halt indication, and allows re-load after halt or by abort.

Parameters:
LOAD_BASE, 8'h00, first memory address written by a frame.
SYNC_BYTE, 8'hA5, frame start / abort byte.
TIMEOUT_CYC, 1024, max idle cycles between frame bytes before error (>=2).
AUTO_RUN, 1, 1 = release CPU after a good load; 0 = wait for run_i pulse.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous reset, active-low.
in_valid  in  1  byte available.
in_data  in  8  byte value.
in_ready  out  1  loader accepts byte this cycle (transfer = in_valid & in_ready).
run_i  in  1  start CPU when AUTO_RUN=0; ignored otherwise.
halt_i  in  1  CPU is in its halt state.
mem_sel  out  1  1 = loader owns memory address/data/write; 0 = CPU owns it.
mem_we  out  1  memory write strobe, sampled by memory on clk rising edge.
mem_addr  out  8  write address.
mem_wdata  out  8  write data.
cpu_rst_n  out  1  CPU reset, active-low, registered.
busy  out  1  frame in progress (LEN/DATA/CHK).
running  out  1  CPU released and not halted.
done  out  1  CPU reached halt after last load.
err  out  1  sticky error; cleared on next accepted SYNC_BYTE.

Behaviour:
- Reset values: cpu_rst_n=0, mem_sel=1, mem_we=0, in_ready=0, busy=running=done=err=0. The FSM enters S_HDR; address register = LOAD_BASE; count = 0.
- States: S_HDR, S_LEN, S_DATA, S_CHK, S_WAIT, S_START, S_RUN, S_HALT, S_ERR.
- S_HDR: in_ready=1. A non-SYNC byte is discarded. A SYNC byte goes to S_LEN and clears err.
- S_LEN: in_ready=1. The accepted byte loads the count: 0 means 256, 1..255 as given. The address register resets to LOAD_BASE. Next state is S_DATA.
- S_DATA: in_ready=1. mem_we = in_valid combinationally; mem_addr = address register; mem_wdata = in_data; each write lands in the same cycle as the transfer.
  - Per transfer: address increments mod 256 (wraps FF to 00, no error) and count decrements.
  - On the last byte: go to S_CHK if the feature is compiled in, otherwise to S_START (AUTO_RUN=1) or S_WAIT (AUTO_RUN=0).
  - SYNC_BYTE in S_DATA is treated as data.
- S_WAIT: in_ready=0. On a run_i pulse go to S_START.
- S_START: one cycle. mem_sel drops to 0; cpu_rst_n rises on the next edge. Next state is S_RUN.
- S_RUN: running=1. in_ready=1; non-SYNC bytes are discarded.
  - A SYNC byte aborts: cpu_rst_n=0 and mem_sel=1 on the next edge, then S_LEN.
  - halt_i=1 goes to S_HALT. If halt_i and SYNC occur in the same cycle, SYNC wins.
- S_HALT: done=1. cpu_rst_n stays 1 so registers remain inspectable. A SYNC byte re-asserts CPU reset, clears done, and goes to S_LEN.
- Timeout: the idle counter clears on every transfer and on state entry, and counts only in S_LEN/S_DATA/S_CHK. Reaching TIMEOUT_CYC goes to S_ERR.
- S_ERR: err=1, CPU held in reset, mem_sel=1, in_ready=1. A SYNC byte goes to S_LEN and clears err; all other bytes are discarded.
- busy=1 in S_LEN/S_DATA/S_CHK. mem_we is 0 in every state except S_DATA.
- Async reset mid-frame or mid-run returns immediately to reset values; partially written memory is not restored.

Optional Feature:
- Macro: SPM_LOADER_CHKSUM_EN.
- Defined: S_CHK accepts one byte. The 8-bit sum of all data bytes plus the CHK byte must equal 8'h00. On a match, proceed to S_START/S_WAIT; on a mismatch, go to S_ERR with the CPU kept in reset. The sum accumulator clears in S_LEN.
- Undefined: S_CHK, the accumulator and mismatch logic are absent; frames carry no CHK byte.

Decomposition:
- Shared package spm_pkg: state encoding enum, SYNC_BYTE default, memory address width constant (8), and CPU reset polarity constant.
- One natural sub-module, spm_loader_timeout: a loadable idle counter with clear/enable/expire.

Test Plan:
- Frame A5 03 11 22 33 (no CHK build, AUTO_RUN=1): writes 11@00, 22@01, 33@02, three mem_we pulses. S_START is entered after the last byte; cpu_rst_n=1 exactly two edges after the last transfer; mem_sel=0.
- CHK build, A5 03 11 22 33 9A: load succeeds and CPU released. The same frame with CHK 9B gives err=1, cpu_rst_n stays 0, mem_sel=1.
- LOAD_BASE=8'hFE, frame A5 04 01 02 03 04: writes at FE, FF, 00, 01 (wrap), no err.
- Frame A5 02 11, then in_valid low for TIMEOUT_CYC cycles: err=1 and S_ERR entered. The next A5 clears err and accepts a new LEN.
- While running, drive halt_i=1: done=1, running=0, cpu_rst_n=1. Then send A5: cpu_rst_n=0 and done=0 next edge.
- While running, send byte 7E (ignored, no state change), then A5: CPU reset and mem_sel=1 on the next edge. A5 and halt_i together: the abort takes priority.
